// File: rtl/axi4_lite_arbiter_pkg.sv
// Shared definitions for the 2-master AXI4-Lite arbiter: FSM encoding and response codes.
package axi4_lite_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_READ  = 2'b10
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi4_lite_rr_pick.sv
// Two-requester selector: round-robin with a registered pointer, or fixed priority to requester 0.
module axi4_lite_rr_pick #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    // prio_q = 1 means requester 1 wins the next tie (requester 0 was granted last)
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (FIXED_PRIO != 0) begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
        end else if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

    assign prio_d = take_i ? gnt_o[0] : prio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prio_q <= 1'b0;
        else         prio_q <= prio_d;
    end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// 2-master -> 1-slave AXI4-Lite arbiter (M0 = data, M1 = instruction fetch).
// One whole transaction is granted at a time; the slave never sees overlap.
module axi4_lite_arbiter
    import axi4_lite_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                ACLK,
    input  logic                ARESTn,
    // master 0
    input  logic                M0_AW_VALID,
    input  logic [ADDR_W-1:0]   M0_AW_ADDR,
    output logic                M0_AW_READY,
    input  logic                M0_W_VALID,
    input  logic [DATA_W-1:0]   M0_W_DATA,
    input  logic [DATA_W/8-1:0] M0_W_STRB,
    output logic                M0_W_READY,
    output logic                M0_B_VALID,
    output logic [1:0]          M0_B_RESP,
    input  logic                M0_B_READY,
    input  logic                M0_AR_VALID,
    input  logic [ADDR_W-1:0]   M0_AR_ADDR,
    output logic                M0_AR_READY,
    output logic                M0_R_VALID,
    output logic [DATA_W-1:0]   M0_R_DATA,
    output logic [1:0]          M0_R_RESP,
    input  logic                M0_R_READY,
    // master 1
    input  logic                M1_AW_VALID,
    input  logic [ADDR_W-1:0]   M1_AW_ADDR,
    output logic                M1_AW_READY,
    input  logic                M1_W_VALID,
    input  logic [DATA_W-1:0]   M1_W_DATA,
    input  logic [DATA_W/8-1:0] M1_W_STRB,
    output logic                M1_W_READY,
    output logic                M1_B_VALID,
    output logic [1:0]          M1_B_RESP,
    input  logic                M1_B_READY,
    input  logic                M1_AR_VALID,
    input  logic [ADDR_W-1:0]   M1_AR_ADDR,
    output logic                M1_AR_READY,
    output logic                M1_R_VALID,
    output logic [DATA_W-1:0]   M1_R_DATA,
    output logic [1:0]          M1_R_RESP,
    input  logic                M1_R_READY,
    // slave
    output logic                S_AW_VALID,
    output logic [ADDR_W-1:0]   S_AW_ADDR,
    input  logic                S_AW_READY,
    output logic                S_W_VALID,
    output logic [DATA_W-1:0]   S_W_DATA,
    output logic [DATA_W/8-1:0] S_W_STRB,
    input  logic                S_W_READY,
    input  logic                S_B_VALID,
    input  logic [1:0]          S_B_RESP,
    output logic                S_B_READY,
    output logic                S_AR_VALID,
    output logic [ADDR_W-1:0]   S_AR_ADDR,
    input  logic                S_AR_READY,
    input  logic                S_R_VALID,
    input  logic [DATA_W-1:0]   S_R_DATA,
    input  logic [1:0]          S_R_RESP,
    output logic                S_R_READY,
    output logic [1:0]          GRANT
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e state_q;
    logic [1:0] grant_q;
    logic       aw_done_q;
    logic       w_done_q;
    logic       ar_done_q;

    logic [1:0] wr_req;
    logic [1:0] rd_req;
    logic [1:0] req;
    logic [1:0] pick;
    logic       take;

    assign wr_req = {M1_AW_VALID | M1_W_VALID, M0_AW_VALID | M0_W_VALID};
    assign rd_req = {M1_AR_VALID, M0_AR_VALID};
    assign req    = wr_req | rd_req;
    assign take   = (state_q == ST_IDLE) && (|req);

    axi4_lite_rr_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .clk_i  (ACLK),
        .rst_ni (ARESTn),
        .req_i  (req),
        .take_i (take),
        .gnt_o  (pick)
    );

    logic g0;
    logic g1;
    logic wr_act;
    logic rd_act;

    assign g0     = grant_q[0];
    assign g1     = grant_q[1];
    assign wr_act = (state_q == ST_WRITE);
    assign rd_act = (state_q == ST_READ);

    // Request-side mux: grant bits mask each master, so payload is zero when idle
    logic m_aw_valid;
    logic m_w_valid;
    logic m_ar_valid;
    logic m_b_ready;
    logic m_r_ready;

    assign m_aw_valid = (g0 & M0_AW_VALID) | (g1 & M1_AW_VALID);
    assign m_w_valid  = (g0 & M0_W_VALID)  | (g1 & M1_W_VALID);
    assign m_ar_valid = (g0 & M0_AR_VALID) | (g1 & M1_AR_VALID);
    assign m_b_ready  = (g0 & M0_B_READY)  | (g1 & M1_B_READY);
    assign m_r_ready  = (g0 & M0_R_READY)  | (g1 & M1_R_READY);

    assign S_AW_ADDR = ({ADDR_W{g0}} & M0_AW_ADDR) | ({ADDR_W{g1}} & M1_AW_ADDR);
    assign S_W_DATA  = ({DATA_W{g0}} & M0_W_DATA)  | ({DATA_W{g1}} & M1_W_DATA);
    assign S_W_STRB  = ({STRB_W{g0}} & M0_W_STRB)  | ({STRB_W{g1}} & M1_W_STRB);
    assign S_AR_ADDR = ({ADDR_W{g0}} & M0_AR_ADDR) | ({ADDR_W{g1}} & M1_AR_ADDR);

    logic aw_open;
    logic w_open;
    logic ar_open;

    assign aw_open = wr_act & ~aw_done_q;
    assign w_open  = wr_act & ~w_done_q;
    assign ar_open = rd_act & ~ar_done_q;

    assign S_AW_VALID = aw_open & m_aw_valid;
    assign S_W_VALID  = w_open  & m_w_valid;
    assign S_AR_VALID = ar_open & m_ar_valid;
    assign S_B_READY  = wr_act  & m_b_ready;
    assign S_R_READY  = rd_act  & m_r_ready;

    assign M0_AW_READY = g0 & aw_open & S_AW_READY;
    assign M1_AW_READY = g1 & aw_open & S_AW_READY;
    assign M0_W_READY  = g0 & w_open  & S_W_READY;
    assign M1_W_READY  = g1 & w_open  & S_W_READY;
    assign M0_AR_READY = g0 & ar_open & S_AR_READY;
    assign M1_AR_READY = g1 & ar_open & S_AR_READY;

    // Responses pass straight through to the owner; RESP is never rewritten
    assign M0_B_VALID = g0 & wr_act & S_B_VALID;
    assign M1_B_VALID = g1 & wr_act & S_B_VALID;
    assign M0_B_RESP  = (g0 & wr_act) ? S_B_RESP : RESP_OKAY;
    assign M1_B_RESP  = (g1 & wr_act) ? S_B_RESP : RESP_OKAY;
    assign M0_R_VALID = g0 & rd_act & S_R_VALID;
    assign M1_R_VALID = g1 & rd_act & S_R_VALID;
    assign M0_R_DATA  = {DATA_W{g0 & rd_act}} & S_R_DATA;
    assign M1_R_DATA  = {DATA_W{g1 & rd_act}} & S_R_DATA;
    assign M0_R_RESP  = (g0 & rd_act) ? S_R_RESP : RESP_OKAY;
    assign M1_R_RESP  = (g1 & rd_act) ? S_R_RESP : RESP_OKAY;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic b_hs;
    logic r_hs;

    assign aw_hs = S_AW_VALID & S_AW_READY;
    assign w_hs  = S_W_VALID  & S_W_READY;
    assign ar_hs = S_AR_VALID & S_AR_READY;
    assign b_hs  = S_B_VALID  & S_B_READY;
    assign r_hs  = S_R_VALID  & S_R_READY;

    always_ff @(posedge ACLK or negedge ARESTn) begin
        if (!ARESTn) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q <= pick;
                        state_q <= (|(wr_req & pick)) ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if (b_hs) begin
                        state_q   <= ST_IDLE;
                        grant_q   <= 2'b00;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (ar_hs) ar_done_q <= 1'b1;
                    if (r_hs) begin
                        state_q   <= ST_IDLE;
                        grant_q   <= 2'b00;
                        ar_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign GRANT = grant_q;

endmodule
